// File: rtl/ex_muldiv_unit_pkg.sv
// Shared opcodes, FSM state encoding and opcode decode helpers for the EX-stage mul/div unit.
package ex_muldiv_unit_pkg;

  localparam logic [1:0] MD_OP_MULTU = 2'b00;
  localparam logic [1:0] MD_OP_MULT  = 2'b01;
  localparam logic [1:0] MD_OP_DIVU  = 2'b10;
  localparam logic [1:0] MD_OP_DIV   = 2'b11;

  typedef enum logic [2:0] {
    MD_IDLE  = 3'd0,
    MD_PREP  = 3'd1,
    MD_CALC  = 3'd2,
    MD_FIXUP = 3'd3,
    MD_DONE  = 3'd4
  } md_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_md_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step
// on the shared {upper[W:0], lower[W-1:0]} accumulator.
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH:0]   acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] div_shift;
  logic [WIDTH+1:0] div_diff;

  always_comb begin
    mul_sum   = acc[2*WIDTH:WIDTH] + {1'b0, opnd};
    div_shift = {acc[2*WIDTH-1:0], 1'b0};
    div_diff  = {1'b0, div_shift[2*WIDTH:WIDTH]} - {2'b00, opnd};
    acc_next  = {1'b0, acc[2*WIDTH:1]};
    if (is_div) begin
      // Borrow clear means the divisor fits: keep the difference and set the quotient bit.
      if (!div_diff[WIDTH+1])
        acc_next = {div_diff[WIDTH:0], div_shift[WIDTH-1:1], 1'b1};
      else
        acc_next = div_shift;
    end else if (acc[0]) begin
      acc_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative signed/unsigned multiply/divide for EX; returns {hi,lo} and stalls EX while working.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             annul_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             ready_o,
  output logic             div_zero_o,
  output logic             busy_o,
  output logic             stallreq_o
);

  localparam int N     = WIDTH / UNROLL;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  md_state_e          state_reg;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   op1_reg, op2_reg, opnd_reg;
  logic [2*WIDTH:0]   acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               sign_lo_reg, sign_hi_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               ready_reg, div_zero_reg, busy_reg;

  logic               sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH:0]   chain [0:UNROLL];

  assign chain[0] = acc_reg;

  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
      md_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_is_div(op_reg)),
        .acc      (chain[gi]),
        .opnd     (opnd_reg),
        .acc_next (chain[gi+1])
      );
    end
  endgenerate

  always_comb begin
    sign1    = op_is_signed(op_reg) & op1_reg[WIDTH-1];
    sign2    = op_is_signed(op_reg) & op2_reg[WIDTH-1];
    mag1     = sign1 ? -op1_reg : op1_reg;
    mag2     = sign2 ? -op2_reg : op2_reg;
    prod_fix = sign_lo_reg ? -acc_reg[2*WIDTH-1:0] : acc_reg[2*WIDTH-1:0];
    quo_fix  = sign_lo_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = sign_hi_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= MD_IDLE;
      op_reg       <= '0;
      op1_reg      <= '0;
      op2_reg      <= '0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      sign_lo_reg  <= 1'b0;
      sign_hi_reg  <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      ready_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      ready_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      case (state_reg)
        MD_IDLE: begin
          if (start_i) begin
            op_reg    <= op_i;
            op1_reg   <= opdata1_i;
            op2_reg   <= opdata2_i;
            busy_reg  <= 1'b1;
            state_reg <= MD_PREP;
          end
        end
        MD_PREP: begin
          if (annul_i) begin
            busy_reg  <= 1'b0;
            state_reg <= MD_IDLE;
          end else if (op_is_div(op_reg) && op2_reg == '0) begin
            lo_reg       <= '1;
            hi_reg       <= op1_reg;
            ready_reg    <= 1'b1;
            div_zero_reg <= 1'b1;
            state_reg    <= MD_DONE;
          end else begin
            // Divide shifts the dividend out MSB-first; multiply consumes the multiplier LSB-first.
            acc_reg     <= {{(WIDTH+1){1'b0}}, op_is_div(op_reg) ? mag1 : mag2};
            opnd_reg    <= op_is_div(op_reg) ? mag2 : mag1;
            sign_lo_reg <= sign1 ^ sign2;
            sign_hi_reg <= sign1 & op_is_div(op_reg);
            cnt_reg     <= CNT_W'(N - 1);
            state_reg   <= MD_CALC;
          end
        end
        MD_CALC: begin
          if (annul_i) begin
            busy_reg  <= 1'b0;
            state_reg <= MD_IDLE;
          end else begin
            acc_reg <= chain[UNROLL];
            if (cnt_reg == '0) state_reg <= MD_FIXUP;
            else               cnt_reg   <= cnt_reg - CNT_W'(1);
          end
        end
        MD_FIXUP: begin
          if (annul_i) begin
            busy_reg  <= 1'b0;
            state_reg <= MD_IDLE;
          end else begin
            if (op_is_div(op_reg)) begin
              lo_reg <= quo_fix;
              hi_reg <= rem_fix;
            end else begin
              {hi_reg, lo_reg} <= prod_fix;
            end
            ready_reg <= 1'b1;
            state_reg <= MD_DONE;
          end
        end
        MD_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= MD_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= MD_IDLE;
        end
      endcase
    end
  end

  assign hi_o       = hi_reg;
  assign lo_o       = lo_reg;
  assign ready_o    = ready_reg;
  assign div_zero_o = div_zero_reg;
  assign busy_o     = busy_reg;
  assign stallreq_o = start_i & ~ready_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench: UNROLL=1 and UNROLL=4 instances, directed corner cases plus random ops vs a behavioural model.
module tb_ex_muldiv_unit;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start1, start4, annul;
  logic [1:0]  op_s;
  logic [31:0] d1, d2;
  logic [31:0] hi1, lo1, hi4, lo4;
  logic        rdy1, dz1, busy1, stall1;
  logic        rdy4, dz4, busy4, stall4;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_hi1 = '0, last_lo1 = '0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(32), .UNROLL(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .start_i(start1), .op_i(op_s),
    .opdata1_i(d1), .opdata2_i(d2), .annul_i(annul),
    .hi_o(hi1), .lo_o(lo1), .ready_o(rdy1), .div_zero_o(dz1),
    .busy_o(busy1), .stallreq_o(stall1)
  );

  ex_muldiv_unit #(.WIDTH(32), .UNROLL(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .start_i(start4), .op_i(op_s),
    .opdata1_i(d1), .opdata2_i(d2), .annul_i(1'b0),
    .hi_o(hi4), .lo_o(lo4), .ready_o(rdy4), .div_zero_o(dz4),
    .busy_o(busy4), .stallreq_o(stall4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy_of(input int sel);   return (sel == 4) ? rdy4 : rdy1;     endfunction
  function automatic logic dz_of(input int sel);    return (sel == 4) ? dz4 : dz1;       endfunction
  function automatic logic stall_of(input int sel); return (sel == 4) ? stall4 : stall1; endfunction
  function automatic logic [31:0] hi_of(input int sel); return (sel == 4) ? hi4 : hi1;   endfunction
  function automatic logic [31:0] lo_of(input int sel); return (sel == 4) ? lo4 : lo1;   endfunction

  // Reference behaviour from native SV arithmetic, independent of the iterative datapath.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb2;
    int          ia, ib;
    e.tag = "rand"; e.dz = 1'b0; e.hi = '0; e.lo = '0; e.lat = 0;
    case (op)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; {e.hi, e.lo} = p; end
      2'b01: begin
        sa = longint'($signed(a)); sb2 = longint'($signed(b));
        p = 64'(sa * sb2); {e.hi, e.lo} = p;
      end
      2'b10: begin
        if (b == 0) begin e.dz = 1'b1; e.lo = '1; e.hi = a; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      default: begin
        if (b == 0) begin e.dz = 1'b1; e.lo = '1; e.hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.lo = a; e.hi = '0; end
        else begin
          ia = $signed(a); ib = $signed(b);
          e.lo = 32'(ia / ib); e.hi = 32'(ia % ib);
        end
      end
    endcase
    return e;
  endfunction

  task automatic do_op(input int sel, input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t e, g;
    int   cyc;
    logic seen;
    e.tag = tag; e.hi = ehi; e.lo = elo; e.dz = edz;
    e.lat = edz ? 2 : (32 / ((sel == 4) ? 4 : 1)) + 3;
    sb.push_back(e);
    @(negedge clk);
    op_s = op; d1 = a; d2 = b;
    if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, ":stall_busy"}, 64'(stall_of(sel)), 64'(1));
      if (rdy_of(sel)) seen = 1'b1;
    end
    g = sb.pop_front();
    if (!seen) begin
      check({g.tag, ":timeout"}, 64'(0), 64'(1));
    end else begin
      check({g.tag, ":latency"}, 64'(cyc), 64'(g.lat));
      check({g.tag, ":hi"}, 64'(hi_of(sel)), 64'(g.hi));
      check({g.tag, ":lo"}, 64'(lo_of(sel)), 64'(g.lo));
      check({g.tag, ":div_zero"}, 64'(dz_of(sel)), 64'(g.dz));
      check({g.tag, ":stall_done"}, 64'(stall_of(sel)), 64'(0));
    end
    start1 = 1'b0; start4 = 1'b0;
    $display("op=%0d u%0d a=%h b=%h -> hi=%h lo=%h dz=%b cycles=%0d [%s]",
             op, sel, a, b, hi_of(sel), lo_of(sel), dz_of(sel), cyc, g.tag);
    @(negedge clk);
    check({g.tag, ":ready_pulse"}, 64'(rdy_of(sel)), 64'(0));
    check({g.tag, ":hold_lo"}, 64'(lo_of(sel)), 64'(g.lo));
    if (sel == 1) begin last_hi1 = g.hi; last_lo1 = g.lo; end
  endtask

  initial begin
    exp_t        m;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic        saw;

    resetn = 1'b0; start1 = 1'b0; start4 = 1'b0; annul = 1'b0;
    op_s = '0; d1 = '0; d2 = '0;
    repeat (3) @(negedge clk);
    check("reset:hi", 64'(hi1), 64'(0));
    check("reset:lo", 64'(lo1), 64'(0));
    check("reset:ready", 64'(rdy1), 64'(0));
    check("reset:busy", 64'(busy1), 64'(0));
    check("reset:div_zero", 64'(dz1), 64'(0));
    resetn = 1'b1;

    do_op(1, "mult", 2'b01, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    do_op(1, "multu", 2'b00, 32'hFFFF_FFFE, 32'h3, 32'h2, 32'hFFFF_FFFA, 1'b0);
    do_op(1, "div_neg", 2'b11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op(1, "divu", 2'b10, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0);
    do_op(1, "divu_zero", 2'b10, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
    do_op(1, "div_min", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

    // Annul during CALC: unit drops back to IDLE with no result and no output change.
    @(negedge clk);
    op_s = 2'b00; d1 = 32'h1111; d2 = 32'h2222; start1 = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1; start1 = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    check("annul:busy", 64'(busy1), 64'(0));
    check("annul:hold_hi", 64'(hi1), 64'(last_hi1));
    check("annul:hold_lo", 64'(lo1), 64'(last_lo1));
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rdy1) saw = 1'b1;
    end
    check("annul:no_ready", 64'(saw), 64'(0));
    $display("annul at T+10 -> busy=%b ready_seen=%b", busy1, saw);
    do_op(1, "after_annul", 2'b00, 32'h3, 32'h5, 32'h0, 32'hF, 1'b0);

    // Asynchronous reset mid-operation clears outputs without waiting for a clock edge.
    @(negedge clk);
    op_s = 2'b01; d1 = 32'h55; d2 = 32'h77; start1 = 1'b1;
    repeat (20) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid:hi", 64'(hi1), 64'(0));
    check("rst_mid:lo", 64'(lo1), 64'(0));
    check("rst_mid:busy", 64'(busy1), 64'(0));
    check("rst_mid:ready", 64'(rdy1), 64'(0));
    $display("reset at T+20 -> hi=%h lo=%h busy=%b", hi1, lo1, busy1);
    @(negedge clk);
    start1 = 1'b0; resetn = 1'b1;

    do_op(4, "u4_mult", 2'b01, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    do_op(4, "u4_multu", 2'b00, 32'hFFFF_FFFE, 32'h3, 32'h2, 32'hFFFF_FFFA, 1'b0);
    do_op(4, "u4_div_neg", 2'b11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op(4, "u4_divu", 2'b10, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 28);
      if (i == 5) rb = '0;
      m = model(rop, ra, rb);
      do_op((i % 2 == 0) ? 1 : 4, $sformatf("rand%0d", i), rop, ra, rb, m.hi, m.lo, m.dz);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
